// File: rtl/mac_mmio_pkg.sv
// Shared definitions for the MAC accelerator MMIO frontend: register offsets,
// STATUS bit layout and issue FSM states.
package mac_mmio_pkg;

    // Word offsets, i.e. req_addr[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_X      = 2'd1;
    localparam logic [1:0] REG_Y      = 2'd2;
    localparam logic [1:0] REG_RESULT = 2'd3;

    localparam int unsigned ST_PENDING   = 0;
    localparam int unsigned ST_BUSY      = 1;
    localparam int unsigned ST_EMPTY     = 2;
    localparam int unsigned ST_FULL      = 3;
    localparam int unsigned ST_UNDERFLOW = 4;
    localparam int unsigned ST_COUNT     = 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO. Push is ignored when full and pop when empty, so the
// count stays within 0..DEPTH.
module mac_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mac_mmio_frontend.sv
// CPU-side MMIO initiator for the MAC/GCD accelerator: decodes register accesses,
// issues X/Y operands over ready/valid and buffers results for CPU readback.
module mac_mmio_frontend
    import mac_mmio_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  resp_rdata,
    input  logic              acc_input_ready,
    output logic              acc_input_valid,
    output logic [WIDTH-1:0]  acc_x,
    output logic [WIDTH-1:0]  acc_y,
    input  logic              acc_output_valid,
    output logic              acc_output_ready,
    input  logic [WIDTH-1:0]  acc_result,
    input  logic              acc_busy
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_x_q, acc_x_d;
    logic [WIDTH-1:0] acc_y_q, acc_y_d;
    logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic             underflow_q, underflow_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_head;
    logic [CntW-1:0]  fifo_count;
    logic [WIDTH-1:0] status;
    logic [1:0]       reg_sel;
    logic             mapped, accept, issue_hs;
    logic             unused_addr_lsb;

    // Byte lanes within a word do not select anything.
    assign unused_addr_lsb = ^req_addr[1:0];
    assign reg_sel = req_addr[3:2];
    assign mapped  = ((req_addr >> 4) == '0);

    assign req_ready = !resp_valid_q
                    && !(req_wr && mapped && reg_sel == REG_Y && state_q == S_ISSUE);
    assign accept    = req_valid && req_ready;
    assign issue_hs  = (state_q == S_ISSUE) && acc_input_ready;

    assign fifo_push = acc_output_valid && !fifo_full;
    assign fifo_pop  = accept && !req_wr && mapped && reg_sel == REG_RESULT && !fifo_empty;

    always_comb begin
        status                       = '0;
        status[ST_PENDING]           = (state_q == S_ISSUE);
        status[ST_BUSY]              = acc_busy;
        status[ST_EMPTY]             = fifo_empty;
        status[ST_FULL]              = fifo_full;
        status[ST_UNDERFLOW]         = underflow_q;
        status[ST_COUNT +: CntW]     = fifo_count;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        acc_x_d      = acc_x_q;
        acc_y_d      = acc_y_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        underflow_d  = underflow_q;

        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
        if (issue_hs) begin
            state_d = S_IDLE;
        end
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            if (mapped && req_wr) begin
                case (reg_sel)
                    REG_X: x_d = req_wdata;
                    REG_Y: begin
                        // Snapshot X so later X writes do not disturb the in-flight issue.
                        acc_x_d = x_q;
                        acc_y_d = req_wdata;
                        state_d = S_ISSUE;
                    end
                    default: ;
                endcase
            end else if (mapped) begin
                case (reg_sel)
                    REG_STATUS: begin
                        resp_rdata_d = status;
                        underflow_d  = 1'b0;
                    end
                    REG_RESULT: begin
                        if (!fifo_empty) begin
                            resp_rdata_d = fifo_head;
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            acc_x_q      <= '0;
            acc_y_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            acc_x_q      <= acc_x_d;
            acc_y_q      <= acc_y_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            underflow_q  <= underflow_d;
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign acc_input_valid  = (state_q == S_ISSUE);
    assign acc_x            = acc_x_q;
    assign acc_y            = acc_y_q;
    assign acc_output_ready = !fifo_full;

    mac_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (acc_result),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
